// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared width, write-side FSM states and the frame checksum rule
package async_fifo_pkg;
  localparam int DATA_W = 8;
  typedef enum logic {PAYLOAD, TRAILER} state_e;
  function automatic logic [DATA_W-1:0] checksum_next(logic [DATA_W-1:0] acc, logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction
endpackage

// File: rtl/async_fifo_frame_writer_if.sv
// async_fifo_frame_writer_if: upstream stream plus FIFO write-port signals of the frame writer
interface async_fifo_frame_writer_if #(parameter int DATA_W = 8);
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_data_i;
  logic              s_last_i;
  logic              wr_en_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              full_i;
  logic              overflow_i;
  modport master (
    input  s_valid_i, s_data_i, s_last_i, full_i, overflow_i,
    output s_ready_o, wr_en_o, wr_data_o
  );
  modport slave (
    output s_valid_i, s_data_i, s_last_i, full_i, overflow_i,
    input  s_ready_o, wr_en_o, wr_data_o
  );
endinterface

// File: rtl/fifo_skid_stage.sv
// fifo_skid_stage: OUT register plus one-word SKID so a full FIFO never loses or drops a word
module fifo_skid_stage #(
  parameter int W = 9
) (
  input  logic         wr_clk_i,
  input  logic         wr_rst_ni,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  input  logic         full,
  output logic         out_v,
  output logic [W-1:0] out_d,
  output logic         skid_v
);
  logic [W-1:0] skid_d;
  logic         adv;
  assign adv = !out_v || !full;
  // OUT advances when empty or consumed; SKID catches a word arriving while OUT is stalled
  always_ff @(posedge wr_clk_i or negedge wr_rst_ni) begin
    if (!wr_rst_ni) begin
      out_v  <= 1'b0;
      out_d  <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (adv) begin
      if (skid_v) begin
        out_v  <= 1'b1;
        out_d  <= skid_d;
        skid_v <= in_v;
        if (in_v) skid_d <= in_d;
      end else begin
        out_v <= in_v;
        if (in_v) out_d <= in_d;
      end
    end else if (in_v) begin
      skid_v <= 1'b1;
      skid_d <= in_d;
    end
  end
endmodule

// File: rtl/async_fifo_frame_writer.sv
// async_fifo_frame_writer: frames a valid/ready stream into FIFO writes with an XOR trailer per frame
module async_fifo_frame_writer
  import async_fifo_pkg::*;
#(
  parameter int DATA_W = async_fifo_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                         wr_clk_i,
  input  logic                         wr_rst_ni,
  async_fifo_frame_writer_if.master    bus,
  output logic [CNT_W-1:0]             frame_cnt_o,
  output logic [CNT_W-1:0]             stall_cnt_o,
  output logic                         err_o,
  output logic                         busy_o
);
  state_e            state, state_nx;
  logic [DATA_W-1:0] csum, csum_nx;
  logic              skid_v, accept, inj, in_v;
  logic [DATA_W:0]   in_d, out_d;
  assign bus.s_ready_o = !skid_v && state == PAYLOAD;
  assign accept        = bus.s_valid_i && bus.s_ready_o;
  assign inj           = state == TRAILER && !skid_v;
  assign in_v          = accept || inj;
  assign in_d          = inj ? {1'b1, csum} : {1'b0, bus.s_data_i};
  assign bus.wr_data_o = out_d[DATA_W-1:0];
  assign busy_o        = bus.wr_en_o || skid_v || state == TRAILER;
  fifo_skid_stage #(.W(DATA_W + 1)) u_skid (
    .wr_clk_i (wr_clk_i),
    .wr_rst_ni(wr_rst_ni),
    .in_v     (in_v),
    .in_d     (in_d),
    .full     (bus.full_i),
    .out_v    (bus.wr_en_o),
    .out_d    (out_d),
    .skid_v   (skid_v)
  );
  // Next state: last payload word opens the trailer slot, injecting the trailer closes it
  always_comb begin
    state_nx = inj ? PAYLOAD : (accept && bus.s_last_i) ? TRAILER : state;
    csum_nx  = inj ? '0 : accept ? checksum_next(csum, bus.s_data_i) : csum;
  end
  // FSM state and running checksum registers
  always_ff @(posedge wr_clk_i or negedge wr_rst_ni) begin
    if (!wr_rst_ni) begin
      state <= PAYLOAD;
      csum  <= '0;
    end else begin
      state <= state_nx;
      csum  <= csum_nx;
    end
  end
  // Statistics: frames counted on trailer consumption, stalls saturate, overflow is sticky
  always_ff @(posedge wr_clk_i or negedge wr_rst_ni) begin
    if (!wr_rst_ni) begin
      frame_cnt_o <= '0;
      stall_cnt_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if (bus.wr_en_o && !bus.full_i && out_d[DATA_W]) frame_cnt_o <= frame_cnt_o + 1'b1;
      if (bus.wr_en_o && bus.full_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (bus.overflow_i) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_async_fifo_frame_writer.sv
// tb_async_fifo_frame_writer: table frames, directed corner sequences and random stalls vs a queue model
module tb_async_fifo_frame_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frame_cnt, stall_cnt;
  logic        err, busy;
  always #5 clk = ~clk;
  async_fifo_frame_writer_if #(.DATA_W(8)) bus();
  async_fifo_frame_writer #(.DATA_W(8), .CNT_W(16)) dut (
    .wr_clk_i   (clk),
    .wr_rst_ni  (rst_n),
    .bus        (bus),
    .frame_cnt_o(frame_cnt),
    .stall_cnt_o(stall_cnt),
    .err_o      (err),
    .busy_o     (busy)
  );
  typedef struct {
    int         len;
    logic [7:0] w[4];
    logic [7:0] trl;
  } frame_t;
  frame_t     tbl[6];
  int         errors = 0, checks = 0;
  logic [8:0] exp_q[$];
  logic [7:0] acc, held, last_trailer;
  int         mframes, mstall, full_hold;
  bit         stalled, rand_full;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", n, act, exp);
    end
  endtask

  task automatic monitor();
    logic [8:0] e;
    if (!rst_n) begin
      exp_q.delete();
      acc = '0;
      mframes = 0;
      mstall = 0;
      stalled = 0;
      return;
    end
    if (stalled) chk("stall_hold", {bus.wr_en_o, bus.wr_data_o}, {1'b1, held});
    if (bus.wr_en_o && !bus.full_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h, required no write", bus.wr_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("write_data", bus.wr_data_o, e[7:0]);
        if (e[8]) begin
          mframes++;
          last_trailer = e[7:0];
        end
      end
    end
    stalled = bus.wr_en_o && bus.full_i;
    if (stalled) begin
      mstall++;
      held = bus.wr_data_o;
    end
    if (bus.s_valid_i && bus.s_ready_o) begin
      exp_q.push_back({1'b0, bus.s_data_i});
      acc ^= bus.s_data_i;
      if (bus.s_last_i) begin
        exp_q.push_back({1'b1, acc});
        acc = '0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    bus.full_i = rand_full ? ($urandom_range(0, 3) == 0) : (full_hold > 0);
    if (full_hold > 0) full_hold--;
  endtask

  task automatic send(input logic [7:0] d, input logic l, output int waits);
    bit r, ok;
    bus.s_valid_i = 1'b1;
    bus.s_data_i = d;
    bus.s_last_i = l;
    waits = 0;
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      r = bus.s_ready_o;
      tick();
      if (r) begin
        ok = 1;
        break;
      end
      waits++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept of %0h, required accept within 500 cycles", d);
    end
    bus.s_valid_i = 1'b0;
    bus.s_last_i = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got busy=1, required idle within 200 cycles");
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic set_tbl(input int i, input int len, input logic [7:0] a, b, c, d, trl);
    tbl[i].len = len;
    tbl[i].w[0] = a;
    tbl[i].w[1] = b;
    tbl[i].w[2] = c;
    tbl[i].w[3] = d;
    tbl[i].trl = trl;
  endtask

  initial begin
    int w, w2, base, sbase, len;
    bus.s_valid_i = 0;
    bus.s_data_i = '0;
    bus.s_last_i = 0;
    bus.full_i = 0;
    bus.overflow_i = 0;
    rand_full = 0;
    full_hold = 0;
    set_tbl(0, 3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00);
    set_tbl(1, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5);
    set_tbl(2, 2, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'hF0);
    set_tbl(3, 4, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F);
    set_tbl(4, 4, 8'h80, 8'hC3, 8'h3C, 8'h01, 8'h7E);
    set_tbl(5, 3, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h5A);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("idle_wr_en", bus.wr_en_o, 0);
    chk("idle_ready", bus.s_ready_o, 1);
    chk("idle_busy", busy, 0);
    chk("idle_frame_cnt", frame_cnt, 0);
    chk("idle_stall_cnt", stall_cnt, 0);
    chk("idle_err", err, 0);
    for (int i = 0; i < 6; i++) begin
      int tw;
      tw = 0;
      for (int j = 0; j < tbl[i].len; j++) begin
        send(tbl[i].w[j], j == tbl[i].len - 1, w);
        tw += w;
        if (j == 0) chk("latency", {bus.wr_en_o, bus.wr_data_o}, {1'b1, tbl[i].w[0]});
      end
      drain();
      chk("tbl_waits", tw, 0);
      chk("tbl_trailer", last_trailer, tbl[i].trl);
      chk("tbl_frame_cnt", frame_cnt, i + 1);
    end
    base = frame_cnt;
    sbase = stall_cnt;
    send(8'h11, 0, w);
    bus.full_i = 1'b1;
    full_hold = 4;
    send(8'h22, 0, w);
    send(8'h33, 1, w);
    chk("stall_ready_gap", w, 5);
    drain();
    chk("stall_cnt", stall_cnt - sbase, 5);
    chk("stall_trailer", last_trailer, 8'h00);
    chk("stall_frame_cnt", frame_cnt - base, 1);
    chk("stall_err", err, 0);
    base = frame_cnt;
    send(8'hA5, 1, w);
    send(8'h3C, 1, w2);
    chk("b2b_ready_gap", w2, 1);
    drain();
    chk("b2b_trailer", last_trailer, 8'h3C);
    chk("b2b_frame_cnt", frame_cnt - base, 2);
    send(8'h10, 0, w);
    send(8'h20, 0, w);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", bus.wr_en_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.s_ready_o, 1);
    chk("rst_frame_cnt", frame_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    send(8'h01, 1, w);
    drain();
    chk("rst_trailer", last_trailer, 8'h01);
    chk("rst_next_frame_cnt", frame_cnt, 1);
    bus.overflow_i = 1'b1;
    tick();
    bus.overflow_i = 1'b0;
    chk("ovf_set", err, 1);
    repeat (3) tick();
    chk("ovf_sticky", err, 1);
    rst_n = 1'b0;
    #1;
    chk("ovf_clear", err, 0);
    tick();
    rst_n = 1'b1;
    rand_full = 1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        send(8'($urandom), j == len - 1, w);
        if ($urandom_range(0, 3) == 0) tick();
      end
    end
    rand_full = 0;
    tick();
    drain();
    chk("rand_frame_cnt", frame_cnt, mframes);
    chk("rand_stall_cnt", stall_cnt, mstall);
    chk("rand_err", err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
